// File: rtl/pipeline_stall_ctrl_pkg.sv
// pipeline_stall_ctrl_pkg: shared register-file constants and memory wait-state encodings
package pipeline_stall_ctrl_pkg;
  localparam int REG_FILE_ADDRESS_LEN = 4;
  localparam logic [REG_FILE_ADDRESS_LEN-1:0] PC_REG = 4'hF;
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } mem_state_e;
endpackage

// File: rtl/pipeline_stall_ctrl_mem_wait_fsm.sv
// pipeline_stall_ctrl_mem_wait_fsm: stalls the pipeline for MEM_LATENCY cycles per data access
module pipeline_stall_ctrl_mem_wait_fsm
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int MEM_LATENCY = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_req,
  output logic mem_stall,
  output logic mem_done
);
  localparam int CW = $clog2(MEM_LATENCY + 1);
  mem_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // IDLE arms the countdown, BUSY runs it out even if the request drops, DONE lets the pipe advance
  always_comb begin
    state_d = (state_q == ST_IDLE) ? (mem_req ? ST_BUSY : ST_IDLE) :
              (state_q == ST_BUSY) ? ((cnt_q == CW'(1)) ? ST_DONE : ST_BUSY) : ST_IDLE;
    cnt_d = (state_q == ST_IDLE) ? CW'(MEM_LATENCY - 1) :
            (state_q == ST_BUSY) ? cnt_q - 1'b1 : cnt_q;
  end
  // state register; reset abandons any access in flight
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  assign mem_stall = rst & ((state_q == ST_BUSY) | ((state_q == ST_IDLE) & mem_req));
  assign mem_done  = rst & (state_q == ST_DONE);
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: RAW hazard detection, branch flush, memory wait states and stall statistics
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W  = 4,
  parameter int MEM_LATENCY = 4,
  parameter int FWD_EN      = 0,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_src1_valid,
  input  logic                  id_two_src,
  input  logic [REG_ADDR_W-1:0] exe_dest,
  input  logic                  exe_wb_en,
  input  logic                  exe_mem_read,
  input  logic                  exe_branch,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic                  mem_wb_en,
  input  logic                  mem_req,
  output logic                  hazard,
  output logic                  flush,
  output logic                  mem_stall,
  output logic                  mem_done,
  output logic [CNT_W-1:0]      stall_count
);
  localparam logic [REG_ADDR_W-1:0] PC_IDX = REG_ADDR_W'(PC_REG);
  localparam bit FWD = (FWD_EN != 0);
  logic s1_ok, s2_ok, exe_ok, mem_ok, raw;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  pipeline_stall_ctrl_mem_wait_fsm #(.MEM_LATENCY(MEM_LATENCY)) u_fsm (
    .clk      (clk),
    .rst      (rst),
    .mem_req  (mem_req),
    .mem_stall(mem_stall),
    .mem_done (mem_done)
  );
  assign s1_ok  = id_src1_valid & (id_src1 != PC_IDX);
  assign s2_ok  = id_two_src & (id_src2 != PC_IDX);
  assign exe_ok = exe_wb_en & (~FWD | exe_mem_read);
  assign mem_ok = mem_wb_en & ~FWD;
  assign raw    = exe_ok & ((s1_ok & (id_src1 == exe_dest)) | (s2_ok & (id_src2 == exe_dest))) |
                  mem_ok & ((s1_ok & (id_src1 == mem_dest)) | (s2_ok & (id_src2 == mem_dest)));
  assign flush  = rst & exe_branch & ~mem_stall;
  assign hazard = rst & raw & ~mem_stall & ~flush;
  assign cnt_d  = cnt_q + CNT_W'((hazard | mem_stall) & ~&cnt_q);
  // saturating count of stalled cycles
  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign stall_count = rst ? cnt_q : '0;
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: directed and random stimulus checked against a cycle-level reference model
module tb_pipeline_stall_ctrl;
  localparam int L = 4;
  logic clk = 0;
  logic rst;
  logic [3:0] id_src1, id_src2, exe_dest, mem_dest;
  logic id_src1_valid, id_two_src, exe_wb_en, exe_mem_read, exe_branch, mem_wb_en, mem_req;
  logic hz0, fl0, ms0, md0, hz1, fl1, ms1, md1;
  logic [3:0] sc0;
  logic [15:0] sc1;
  int n_vec = 0, n_err = 0;
  int m_phase = -1, m_c0 = 0, m_c1 = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.MEM_LATENCY(L), .FWD_EN(0), .CNT_W(4)) u0 (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2), .id_src1_valid(id_src1_valid),
    .id_two_src(id_two_src), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
    .exe_mem_read(exe_mem_read), .exe_branch(exe_branch), .mem_dest(mem_dest),
    .mem_wb_en(mem_wb_en), .mem_req(mem_req), .hazard(hz0), .flush(fl0), .mem_stall(ms0),
    .mem_done(md0), .stall_count(sc0));

  pipeline_stall_ctrl #(.MEM_LATENCY(L), .FWD_EN(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2), .id_src1_valid(id_src1_valid),
    .id_two_src(id_two_src), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
    .exe_mem_read(exe_mem_read), .exe_branch(exe_branch), .mem_dest(mem_dest),
    .mem_wb_en(mem_wb_en), .mem_req(mem_req), .hazard(hz1), .flush(fl1), .mem_stall(ms1),
    .mem_done(md1), .stall_count(sc1));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit raw_exp(input bit fwd);
    bit r = 0;
    for (int s = 0; s < 2; s++)
      for (int t = 0; t < 2; t++) begin
        logic [3:0] src = s ? id_src2 : id_src1;
        logic [3:0] dst = t ? mem_dest : exe_dest;
        bit sv = s ? id_two_src : id_src1_valid;
        bit wb = t ? (mem_wb_en && !fwd) : (exe_wb_en && (!fwd || exe_mem_read));
        if (sv && wb && src != 4'hF && src == dst) r = 1;
      end
    return r;
  endfunction

  task automatic cycle();
    bit ms_e, md_e, fl_e, h0, h1;
    #1;
    ms_e = rst && ((m_phase < 0 && mem_req) || (m_phase >= 1 && m_phase < L));
    md_e = rst && (m_phase == L);
    fl_e = rst && exe_branch && !ms_e;
    h0 = rst && raw_exp(0) && !ms_e && !fl_e;
    h1 = rst && raw_exp(1) && !ms_e && !fl_e;
    chk("hazard0", 16'(hz0), 16'(h0));
    chk("hazard1", 16'(hz1), 16'(h1));
    chk("flush0", 16'(fl0), 16'(fl_e));
    chk("flush1", 16'(fl1), 16'(fl_e));
    chk("mem_stall0", 16'(ms0), 16'(ms_e));
    chk("mem_stall1", 16'(ms1), 16'(ms_e));
    chk("mem_done0", 16'(md0), 16'(md_e));
    chk("mem_done1", 16'(md1), 16'(md_e));
    chk("stall_count0", 16'(sc0), rst ? 16'(m_c0) : 16'd0);
    chk("stall_count1", sc1, rst ? 16'(m_c1) : 16'd0);
    @(posedge clk);
    if (!rst) begin
      m_phase = -1;
      m_c0 = 0;
      m_c1 = 0;
    end else begin
      m_phase = (m_phase < 0) ? (mem_req ? 1 : -1) : (m_phase == L) ? -1 : m_phase + 1;
      m_c0 = (m_c0 + int'(h0 || ms_e) > 15) ? 15 : m_c0 + int'(h0 || ms_e);
      m_c1 = (m_c1 + int'(h1 || ms_e) > 65535) ? 65535 : m_c1 + int'(h1 || ms_e);
    end
    @(negedge clk);
  endtask

  function automatic logic [3:0] rnd_reg();
    return ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 3));
  endfunction

  initial begin
    rst = 0; mem_req = 1;
    id_src1 = 0; id_src2 = 0; exe_dest = 0; mem_dest = 0;
    id_src1_valid = 0; id_two_src = 0; exe_wb_en = 0; exe_mem_read = 0;
    exe_branch = 0; mem_wb_en = 0;
    @(negedge clk);
    cycle(); cycle();
    rst = 1;
    repeat (10) cycle();
    mem_req = 0;
    repeat (2) cycle();
    id_src1_valid = 1; id_src1 = 3; exe_dest = 3; exe_wb_en = 1;
    cycle();
    exe_wb_en = 0;
    cycle();
    exe_wb_en = 1; id_src1 = 15; exe_dest = 15;
    cycle();
    id_src1_valid = 0; exe_mem_read = 1; exe_dest = 5; id_src2 = 5; id_two_src = 1;
    cycle();
    exe_mem_read = 0;
    cycle();
    exe_wb_en = 0; mem_wb_en = 1; mem_dest = 5;
    cycle();
    exe_branch = 1;
    cycle();
    exe_branch = 0; mem_req = 1;
    cycle();
    mem_req = 0; exe_branch = 1;
    repeat (4) cycle();
    exe_branch = 0;
    cycle();
    mem_req = 1;
    repeat (2) cycle();
    rst = 0;
    cycle();
    rst = 1; mem_req = 0;
    repeat (2) cycle();
    mem_wb_en = 0; id_two_src = 0; mem_req = 1;
    repeat (25) cycle();
    mem_req = 0;
    cycle();
    for (int i = 0; i < 300; i++) begin
      rst = ($urandom_range(0, 39) != 0);
      id_src1 = rnd_reg(); id_src2 = rnd_reg(); exe_dest = rnd_reg(); mem_dest = rnd_reg();
      id_src1_valid = 1'($urandom); id_two_src = 1'($urandom);
      exe_wb_en = 1'($urandom); exe_mem_read = 1'($urandom); mem_wb_en = 1'($urandom);
      exe_branch = ($urandom_range(0, 5) == 0);
      mem_req = ($urandom_range(0, 3) == 0);
      cycle();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
